// File: rtl/packet_serializer.sv
// packet_serializer: turns a parallel payload into a 9-bit {k, byte} serial word stream,
// LSB first. Each packet is NUM_HDR comma words followed by NUM_BYTES data words. Idle
// commas fill the line between packets.
// Optional feature: define PKT_SER_CRC_EN to append one XOR-checksum word to every packet.

module packet_serializer #(
   parameter int unsigned NUM_BYTES = 3,
   parameter int unsigned NUM_HDR   = 1,
   parameter logic [7:0]  COMMA     = 8'h3C
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [NUM_BYTES*8-1:0] data_i,
   output logic                   ready_o,
   output logic                   data_o,
   output logic                   ena_o,
   output logic                   eot_o
);

   localparam int unsigned W         = NUM_BYTES * 8;
   localparam logic [8:0]  KWORD     = {1'b1, COMMA};
   localparam logic [3:0]  LAST_HDR  = 4'(NUM_HDR - 1);
   localparam logic [3:0]  LAST_BYTE = 4'(NUM_BYTES - 1);

`ifdef PKT_SER_CRC_EN
   typedef enum logic [1:0] {StIdle, StHdr, StData, StCrc} state_t;
`else
   typedef enum logic [1:0] {StIdle, StHdr, StData} state_t;
`endif

   state_t         state_q;
   logic [3:0]     cnt_q;      // bit position of the word on the line
   logic [3:0]     idx_q;      // header/data word index within the current state
   logic [8:0]     shift_q;
   logic [W-1:0]   pend_q;
   logic           pend_vld_q;
   logic [W-1:0]   work_q;     // payload of the packet in flight, consumed low byte first
   logic           ena_q;
   logic           eot_q;
`ifdef PKT_SER_CRC_EN
   logic [7:0]     crc_q;
`endif

   logic           wrap;
   logic           accept;
   logic           last_word;

   // Word boundary, request acceptance and "current word ends the packet" decode
   always_comb begin
      wrap   = (cnt_q == 4'd8);
      accept = start_i && !pend_vld_q;
`ifdef PKT_SER_CRC_EN
      last_word = (state_q == StCrc);
`else
      last_word = (state_q == StData) && (idx_q == LAST_BYTE);
`endif
   end

   // Bit counter, pending buffer, packet FSM and shift register; strobes registered one
   // cycle early so they line up with the last bit of each word
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         idx_q      <= 4'd0;
         shift_q    <= KWORD;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         work_q     <= '0;
         ena_q      <= 1'b0;
         eot_q      <= 1'b0;
`ifdef PKT_SER_CRC_EN
         crc_q      <= 8'h00;
`endif
      end else begin
         cnt_q <= wrap ? 4'd0 : cnt_q + 4'd1;
         ena_q <= (cnt_q == 4'd7);
         eot_q <= (cnt_q == 4'd7) && last_word;

         if (accept) begin
            pend_q     <= data_i;
            pend_vld_q <= 1'b1;
         end

         if (!wrap) begin
            shift_q <= {1'b0, shift_q[8:1]};
         end else begin
            shift_q <= KWORD;
            if (state_q == StIdle || last_word) begin
               // Start the next packet straight away if one is waiting (no idle gap)
               if (pend_vld_q) begin
                  state_q    <= StHdr;
                  idx_q      <= 4'd0;
                  work_q     <= pend_q;
                  pend_vld_q <= 1'b0;
`ifdef PKT_SER_CRC_EN
                  crc_q      <= 8'h00;
`endif
               end else begin
                  state_q <= StIdle;
               end
            end else begin
               unique case (state_q)
                  StHdr: begin
                     if (idx_q == LAST_HDR) begin
                        state_q <= StData;
                        idx_q   <= 4'd0;
                        shift_q <= {1'b0, work_q[7:0]};
                        work_q  <= work_q >> 8;
`ifdef PKT_SER_CRC_EN
                        crc_q   <= crc_q ^ work_q[7:0];
`endif
                     end else begin
                        idx_q <= idx_q + 4'd1;
                     end
                  end
                  StData: begin
`ifdef PKT_SER_CRC_EN
                     if (idx_q == LAST_BYTE) begin
                        state_q <= StCrc;
                        shift_q <= {1'b0, crc_q};
                     end else begin
                        idx_q   <= idx_q + 4'd1;
                        shift_q <= {1'b0, work_q[7:0]};
                        work_q  <= work_q >> 8;
                        crc_q   <= crc_q ^ work_q[7:0];
                     end
`else
                     idx_q   <= idx_q + 4'd1;
                     shift_q <= {1'b0, work_q[7:0]};
                     work_q  <= work_q >> 8;
`endif
                  end
                  default: state_q <= StIdle;
               endcase
            end
         end
      end
   end

   // Output mapping
   always_comb begin
      ready_o = !pend_vld_q;
      data_o  = shift_q[0];
      ena_o   = ena_q;
      eot_o   = eot_q;
   end

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer: a default instance (3 bytes, 1 header) and a
// small instance (1 byte, 2 headers). Serial words are reassembled on the falling edge
// and queued as {eot, word}.

module tb_packet_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start_a = 1'b0;
   logic [23:0] din_a   = '0;
   logic        ready_a, data_a, ena_a, eot_a;

   logic        start_b = 1'b0;
   logic [7:0]  din_b   = '0;
   logic        ready_b, data_b, ena_b, eot_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0]  sh_a = '0;
   logic [8:0]  sh_b = '0;
   logic [9:0]  q_a[$];
   logic [9:0]  q_b[$];
   int          bad_eot_a = 0;
   int          bad_eot_b = 0;

   always #5 clk = ~clk;

   packet_serializer u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start_a),
      .data_i  (din_a),
      .ready_o (ready_a),
      .data_o  (data_a),
      .ena_o   (ena_a),
      .eot_o   (eot_a)
   );

   packet_serializer #(
      .NUM_BYTES (1),
      .NUM_HDR   (2)
   ) u_small (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start_b),
      .data_i  (din_b),
      .ready_o (ready_b),
      .data_o  (data_b),
      .ena_o   (ena_b),
      .eot_o   (eot_b)
   );

   // Reassemble words LSB first; a word is complete on the cycle ena is high
   always @(negedge clk) begin
      sh_a = {data_a, sh_a[8:1]};
      sh_b = {data_b, sh_b[8:1]};
      if (ena_a) q_a.push_back({eot_a, sh_a});
      if (ena_b) q_b.push_back({eot_b, sh_b});
      if (eot_a && !ena_a) bad_eot_a++;
      if (eot_b && !ena_b) bad_eot_b++;
   end

   function automatic int n_eot(input logic [9:0] q[$]);
      int n = 0;
      foreach (q[i]) if (q[i][9]) n++;
      return n;
   endfunction

   function automatic int eot_idx(input logic [9:0] q[$], input int k);
      int n = 0;
      foreach (q[i]) begin
         if (q[i][9]) begin
            n++;
            if (n == k) return i;
         end
      end
      return -1;
   endfunction

   function automatic bit has_word(input logic [9:0] q[$], input logic [9:0] w);
      foreach (q[i]) if (q[i] == w) return 1'b1;
      return 1'b0;
   endfunction

   task automatic pulse_start_a(input logic [23:0] d);
      @(posedge clk); #1;
      din_a   = d;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
   endtask

   task automatic wait_eot(input bit sel_b, input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(posedge clk);
         if ((sel_b ? n_eot(q_b) : n_eot(q_a)) >= n) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      #2;
      n_checks++;
      if ({data_a, ena_a, eot_a, ready_a} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_a: got {data,ena,eot,ready}=%b expected 0001",
                  {data_a, ena_a, eot_a, ready_a});
      end
      n_checks++;
      if ({data_b, ena_b, eot_b, ready_b} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_b: got {data,ena,eot,ready}=%b expected 0001",
                  {data_b, ena_b, eot_b, ready_b});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (22) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({data_a, ena_a, eot_a, ready_a} !== 4'b0001) begin
         n_fail++;
         $display("FAIL async_reset_a: got {data,ena,eot,ready}=%b expected 0001",
                  {data_a, ena_a, eot_a, ready_a});
      end
      n_checks++;
      if ({data_b, ena_b, eot_b, ready_b} !== 4'b0001) begin
         n_fail++;
         $display("FAIL async_reset_b: got {data,ena,eot,ready}=%b expected 0001",
                  {data_b, ena_b, eot_b, ready_b});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      q_a.delete();
      q_b.delete();
      repeat (27) @(posedge clk);
      n_checks++;
      if (q_a.size() !== 3) begin
         n_fail++;
         $display("FAIL idle_count: got %0d words expected 3", q_a.size());
      end
      foreach (q_a[i]) begin
         n_checks++;
         if (q_a[i] !== 10'h13C) begin
            n_fail++;
            $display("FAIL idle_word %0d: got %h expected 13c", i, q_a[i]);
         end
      end
   endtask

   task automatic test_single;
      logic [9:0] exp[$];
      int         i, s;
      bit         ok;
      exp.push_back(10'h13C);
      exp.push_back(10'h0C3);
      exp.push_back(10'h0B2);
`ifdef PKT_SER_CRC_EN
      exp.push_back(10'h0A1);
      exp.push_back(10'h2D0);
`else
      exp.push_back(10'h2A1);
`endif
      q_a.delete();
      @(posedge clk); #1;
      n_checks++;
      if (ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready_before: got %b expected 1", ready_a);
      end
      pulse_start_a(24'hA1B2C3);
      n_checks++;
      if (ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ready_after: got %b expected 0", ready_a);
      end
      wait_eot(1'b0, 1, 200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_timeout: got no eot expected one within 200 clocks");
      end
      repeat (18) @(posedge clk);
      i = eot_idx(q_a, 1);
      s = i - exp.size() + 1;
      n_checks++;
      if (s < 1 || s > 2) begin
         n_fail++;
         $display("FAIL single_start_pos: got header at word %0d expected 1 or 2", s);
      end else begin
         for (int j = 0; j < s; j++) begin
            n_checks++;
            if (q_a[j] !== 10'h13C) begin
               n_fail++;
               $display("FAIL single_pre_idle %0d: got %h expected 13c", j, q_a[j]);
            end
         end
         foreach (exp[j]) begin
            n_checks++;
            if (q_a[s+j] !== exp[j]) begin
               n_fail++;
               $display("FAIL single_word %0d: got %h expected %h", j, q_a[s+j], exp[j]);
            end
         end
      end
      n_checks++;
      if (i < 0 || q_a.size() < i + 3) begin
         n_fail++;
         $display("FAIL single_post_len: got %0d words expected at least %0d", q_a.size(), i + 3);
      end else begin
         n_checks++;
         if ({q_a[i+1], q_a[i+2]} !== {10'h13C, 10'h13C}) begin
            n_fail++;
            $display("FAIL single_post_idle: got %h %h expected 13c 13c", q_a[i+1], q_a[i+2]);
         end
      end
      n_checks++;
      if (n_eot(q_a) !== 1) begin
         n_fail++;
         $display("FAIL single_eot_count: got %0d expected 1", n_eot(q_a));
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] exp1[$];
      logic [9:0] exp2[$];
      int         i1, i2;
      bit         ok;
      exp1.push_back(10'h13C); exp1.push_back(10'h0C3); exp1.push_back(10'h0B2);
      exp2.push_back(10'h13C); exp2.push_back(10'h001); exp2.push_back(10'h002);
`ifdef PKT_SER_CRC_EN
      exp1.push_back(10'h0A1); exp1.push_back(10'h2D0);
      exp2.push_back(10'h003); exp2.push_back(10'h200);
`else
      exp1.push_back(10'h2A1);
      exp2.push_back(10'h203);
`endif
      q_a.delete();
      pulse_start_a(24'hA1B2C3);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(posedge clk); #1;
         if (ready_a === 1'b1) ok = 1'b1;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL b2b_consume: got ready=%b expected 1 within 20 clocks", ready_a);
      end
      pulse_start_a(24'h030201);
      n_checks++;
      if (ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ready_full: got %b expected 0", ready_a);
      end
      repeat (3) @(posedge clk);
      pulse_start_a(24'hFFFFFF);
      n_checks++;
      if (ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ready_still_full: got %b expected 0", ready_a);
      end
      wait_eot(1'b0, 2, 400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d eots expected 2 within 400 clocks", n_eot(q_a));
      end
      repeat (18) @(posedge clk); #1;
      i1 = eot_idx(q_a, 1);
      i2 = eot_idx(q_a, 2);
      n_checks++;
      if (i1 < 0 || i2 - i1 !== exp2.size()) begin
         n_fail++;
         $display("FAIL b2b_gap: got eots at words %0d and %0d expected %0d apart",
                  i1, i2, exp2.size());
      end else begin
         foreach (exp1[j]) begin
            n_checks++;
            if (i1 - exp1.size() + 1 + j < 0 || q_a[i1-exp1.size()+1+j] !== exp1[j]) begin
               n_fail++;
               $display("FAIL b2b_pkt1 word %0d: expected %h", j, exp1[j]);
            end
         end
         foreach (exp2[j]) begin
            n_checks++;
            if (q_a[i1+1+j] !== exp2[j]) begin
               n_fail++;
               $display("FAIL b2b_pkt2 word %0d: got %h expected %h", j, q_a[i1+1+j], exp2[j]);
            end
         end
         n_checks++;
         if (q_a.size() < i2 + 3 || {q_a[i2+1], q_a[i2+2]} !== {10'h13C, 10'h13C}) begin
            n_fail++;
            $display("FAIL b2b_third_ignored: got non-idle or missing words after eot, expected 13c 13c");
         end
      end
      n_checks++;
      if (ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready_end: got %b expected 1", ready_a);
      end
   endtask

   task automatic test_reset_mid_data;
      bit ok;
      q_a.delete();
      pulse_start_a(24'hA1B2C3);
      repeat (12) @(posedge clk);
      pulse_start_a(24'h030201);
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(posedge clk);
         if (has_word(q_a, 10'h0C3)) ok = 1'b1;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL mid_reset_wait: got no 0c3 word expected one within 100 clocks");
      end
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (n_eot(q_a) !== 0) begin
         n_fail++;
         $display("FAIL mid_reset_no_eot: got %0d eots expected 0", n_eot(q_a));
      end
      n_checks++;
      if (ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_ready: got %b expected 1", ready_a);
      end
      q_a.delete();
      repeat (36) @(posedge clk);
      n_checks++;
      if (q_a.size() !== 4) begin
         n_fail++;
         $display("FAIL mid_reset_idle_count: got %0d words expected 4", q_a.size());
      end
      foreach (q_a[i]) begin
         n_checks++;
         if (q_a[i] !== 10'h13C) begin
            n_fail++;
            $display("FAIL mid_reset_idle %0d: got %h expected 13c", i, q_a[i]);
         end
      end
   endtask

   task automatic test_small;
      logic [9:0] exp[$];
      int         i, s;
      bit         ok;
      exp.push_back(10'h13C);
      exp.push_back(10'h13C);
`ifdef PKT_SER_CRC_EN
      exp.push_back(10'h05A);
      exp.push_back(10'h25A);
`else
      exp.push_back(10'h25A);
`endif
      q_b.delete();
      @(posedge clk); #1;
      din_b   = 8'h5A;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      n_checks++;
      if (ready_b !== 1'b0) begin
         n_fail++;
         $display("FAIL small_ready_after: got %b expected 0", ready_b);
      end
      wait_eot(1'b1, 1, 200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL small_timeout: got no eot expected one within 200 clocks");
      end
      repeat (18) @(posedge clk);
      i = eot_idx(q_b, 1);
      s = i - exp.size() + 1;
      n_checks++;
      if (s < 0) begin
         n_fail++;
         $display("FAIL small_start_pos: got eot at word %0d expected at least %0d", i, exp.size() - 1);
      end else begin
         foreach (exp[j]) begin
            n_checks++;
            if (q_b[s+j] !== exp[j]) begin
               n_fail++;
               $display("FAIL small_word %0d: got %h expected %h", j, q_b[s+j], exp[j]);
            end
         end
      end
      n_checks++;
      if (n_eot(q_b) !== 1) begin
         n_fail++;
         $display("FAIL small_eot_count: got %0d expected 1", n_eot(q_b));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid_data();
      test_small();
      n_checks++;
      if (bad_eot_a !== 0) begin
         n_fail++;
         $display("FAIL eot_outside_ena_a: got %0d stray pulses expected 0", bad_eot_a);
      end
      n_checks++;
      if (bad_eot_b !== 0) begin
         n_fail++;
         $display("FAIL eot_outside_ena_b: got %0d stray pulses expected 0", bad_eot_b);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
